microwave_sequencer: RTL and testbench
======================================

Name: microwave_sequencer

Overview:
- Control FSM and BCD countdown timer for the microwave oven.
- Accepts keypad digits into an M:SS preset and sequences cook, pause and done.
- Gates the magnetron and generates the 1 s tick internally.
- Sits between the keypad/button/door inputs and the 7-segment decoders; its BCD outputs feed the existing segment drivers directly.

Parameters:
CLK_PER_SEC, 100000, clock cycles per timer second (bench overrides to 10)
TICK_W, 17, width of internal tick counter; must satisfy 2**TICK_W >= CLK_PER_SEC

Ports:
clock  input  1  system clock, all logic on rising edge
clear  input  1  synchronous active-high reset
keypad  input  10  one-hot digit keys, bit n = digit n, level while held
startn  input  1  start button, active low
stopn  input  1  stop/clear button, active low
door_closed  input  1  1 = door closed
min_bcd  output  4  minutes digit, 0..9
sec_tens_bcd  output  4  seconds tens digit, 0..5
sec_ones_bcd  output  4  seconds ones digit, 0..9
mag_on  output  1  magnetron enable
state  output  2  00 IDLE, 01 COOK, 10 PAUSE, 11 DONE
done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset
  - clear=1 at a rising edge: state=IDLE, all BCD digits=0, mag_on=0, done=0.
  - Tick counter=0; edge-detect registers load current input values so no false edge follows reset.
  - clear mid-cook aborts immediately; mag_on=0 on the next cycle.
- Inputs are already synchronous to clock.
- Edge events, registered one cycle:
  - key_ev = keypad goes from all-zero to non-zero.
  - start_ev = startn falling edge.
  - stop_ev = stopn falling edge.
  - Multiple key bits set: highest index wins.
- Digit entry, IDLE only, on key_ev: min<=sec_tens, sec_tens<=min(sec_ones,5), sec_ones<=digit. Example: keys 2,5,9,0,0 give 0:02, 0:25, 2:59, 5:90→5:50, then 5:00.
- IDLE
  - stop_ev clears all digits to 0:00.
  - start_ev with door_closed=1 and time≠0:00: go to COOK; tick counter=0.
  - start_ev ignored if door open or time=0:00.
- COOK
  - mag_on=1.
  - Tick counter increments each cycle; at CLK_PER_SEC-1 it wraps to 0 and fires tick. First decrement occurs exactly CLK_PER_SEC cycles after COOK entry.
  - Decrement on tick:
    - ones>0: ones-1.
    - Else tens>0: tens-1, ones=9.
    - Else: min-1, tens=5, ones=9.
  - Tick that produces 0:00: go to DONE the same edge; done pulses 1 cycle.
  - door_closed=0: go to PAUSE; a tick in the same cycle is discarded.
  - stop_ev: go to PAUSE.
  - keypad ignored.
- PAUSE
  - mag_on=0; digits hold; tick counter holds.
  - start_ev with door_closed=1: back to COOK, tick counter resumes from held value.
  - stop_ev: IDLE with digits cleared to 0:00.
  - keypad ignored.
- DONE
  - mag_on=0; digits 0:00.
  - Any key_ev, start_ev or stop_ev returns to IDLE and is consumed; a key is not entered.
- Priority for simultaneous events in one cycle: clear > door open > stop_ev > start_ev > key_ev.
- mag_on is registered and equals (state==COOK) one cycle after the state register. It is never 1 while door_closed=0 for more than one cycle.
- Digit width rules: tens never exceeds 5 in any state; minutes never wrap below 0.

Optional Feature:
- Macro: QUICK_START_EN.
- Defined:
  - start_ev in IDLE with time 0:00 and door closed loads 0:30 and enters COOK.
  - start_ev in COOK adds 30 s with BCD carry, saturating at 9:59; tick counter unaffected.
- Undefined: these cases are ignored, as above.

Test Plan (CLK_PER_SEC=10):
- Reset then keys 2,5,9,0,0 with releases -> digits 0:02, 0:25, 2:59, 5:50, 5:00; state=00, mag_on=0.
- Preset 0:12, door closed, start_ev -> state=01, mag_on=1 next cycle; after 10 cycles shows 0:11, after 30 cycles shows 0:09.
- Preset 1:00, cook, tick -> 0:59; preset 0:01, cook, tick -> 0:00, state=11, done high exactly 1 cycle, mag_on=0.
- Cook with 0:05, door opens 4 cycles into a second -> PAUSE, digits hold. Close door, start -> next decrement 6 cycles later.
- start_ev with door open or time 0:00 -> state stays 00. stop and start asserted same cycle in COOK -> PAUSE.
- clear asserted mid-COOK at 3:17 -> next cycle 0:00, state=00, mag_on=0. With QUICK_START_EN: start at 9:45 in COOK -> 9:59.

Source files
------------

// File: rtl/microwave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : microwave_sequencer
// Brief    : Microwave control FSM with keypad M:SS entry and BCD countdown.
//            Optional macro QUICK_START_EN enables the +30 s quick-start button.
// Revision : 1.0  initial release
// ============================================================================
module microwave_sequencer #(
    parameter int CLK_PER_SEC = 100000,
    parameter int TICK_W      = 17
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       mag_on,
    output logic [1:0] state,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOK  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(CLK_PER_SEC - 1);

    state_t            r_state, w_state_nxt;
    logic              r_key_any_d, r_startn_d, r_stopn_d;
    logic              r_key_ev, r_start_ev, r_stop_ev;
    logic [3:0]        r_key_digit, w_key_digit;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [3:0]        r_min, r_tens, r_ones;
    logic [3:0]        w_min_nxt, w_tens_nxt, w_ones_nxt;
    logic [3:0]        w_dec_min, w_dec_tens, w_dec_ones;
    logic [3:0]        w_ck_min, w_ck_tens, w_ck_ones;
    logic              r_mag_on, r_done;
    logic              w_tick, w_time_zero;

    // Highest pressed key wins when several are held together.
    always_comb begin
        w_key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) w_key_digit = 4'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_key_any_d <= |keypad;
            r_startn_d  <= startn;
            r_stopn_d   <= stopn;
            r_key_ev    <= 1'b0;
            r_start_ev  <= 1'b0;
            r_stop_ev   <= 1'b0;
            r_key_digit <= 4'd0;
        end else begin
            r_key_any_d <= |keypad;
            r_startn_d  <= startn;
            r_stopn_d   <= stopn;
            r_key_ev    <= (|keypad) & ~r_key_any_d;
            r_start_ev  <= r_startn_d & ~startn;
            r_stop_ev   <= r_stopn_d & ~stopn;
            r_key_digit <= w_key_digit;
        end
    end

    assign w_tick      = (r_tick_cnt == C_TICK_LAST);
    assign w_time_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_tens = r_tens - 4'd1;
            w_dec_ones = 4'd9;
        end else begin
            w_dec_min  = r_min - 4'd1;
            w_dec_tens = 4'd5;
            w_dec_ones = 4'd9;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_min_nxt      = r_min;
        w_tens_nxt     = r_tens;
        w_ones_nxt     = r_ones;
        w_tick_cnt_nxt = r_tick_cnt;
        w_ck_min       = r_min;
        w_ck_tens      = r_tens;
        w_ck_ones      = r_ones;
        case (r_state)
            ST_IDLE: begin
                if (r_stop_ev) begin
                    w_min_nxt  = 4'd0;
                    w_tens_nxt = 4'd0;
                    w_ones_nxt = 4'd0;
                end else if (r_start_ev && door_closed && !w_time_zero) begin
                    w_state_nxt    = ST_COOK;
                    w_tick_cnt_nxt = '0;
`ifdef QUICK_START_EN
                end else if (r_start_ev && door_closed) begin
                    w_state_nxt    = ST_COOK;
                    w_tens_nxt     = 4'd3;
                    w_tick_cnt_nxt = '0;
`endif
                end else if (r_key_ev) begin
                    w_min_nxt  = r_tens;
                    w_tens_nxt = (r_ones > 4'd5) ? 4'd5 : r_ones;
                    w_ones_nxt = r_key_digit;
                end
            end
            ST_COOK: begin
                // Leaving COOK freezes the counter so a resume keeps the partial second.
                if (!door_closed || r_stop_ev) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
                    if (w_tick) begin
                        w_ck_min  = w_dec_min;
                        w_ck_tens = w_dec_tens;
                        w_ck_ones = w_dec_ones;
                    end
`ifdef QUICK_START_EN
                    if (r_start_ev) begin
                        if (w_ck_tens >= 4'd3) begin
                            if (w_ck_min == 4'd9) begin
                                w_ck_tens = 4'd5;
                                w_ck_ones = 4'd9;
                            end else begin
                                w_ck_min  = w_ck_min + 4'd1;
                                w_ck_tens = w_ck_tens - 4'd3;
                            end
                        end else begin
                            w_ck_tens = w_ck_tens + 4'd3;
                        end
                    end
`endif
                    w_min_nxt  = w_ck_min;
                    w_tens_nxt = w_ck_tens;
                    w_ones_nxt = w_ck_ones;
                    if ((w_ck_min == 4'd0) && (w_ck_tens == 4'd0) && (w_ck_ones == 4'd0)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (r_stop_ev) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 4'd0;
                    w_tens_nxt  = 4'd0;
                    w_ones_nxt  = 4'd0;
                end else if (r_start_ev && door_closed) begin
                    w_state_nxt = ST_COOK;
                end
            end
            default: begin
                w_min_nxt  = 4'd0;
                w_tens_nxt = 4'd0;
                w_ones_nxt = 4'd0;
                if (r_key_ev || r_start_ev || r_stop_ev) w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_min      <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_tick_cnt <= '0;
            r_mag_on   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_min      <= w_min_nxt;
            r_tens     <= w_tens_nxt;
            r_ones     <= w_ones_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_mag_on   <= (r_state == ST_COOK);
            r_done     <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
        end
    end

    assign min_bcd      = r_min;
    assign sec_tens_bcd = r_tens;
    assign sec_ones_bcd = r_ones;
    assign mag_on       = r_mag_on;
    assign state        = r_state;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_microwave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_sequencer
// Brief    : Scoreboard bench for microwave_sequencer with a seconds-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_microwave_sequencer;

    localparam int CPS = 10;
    localparam int S_IDLE = 0, S_COOK = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clock = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       startn, stopn, door_closed;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic       mag_on, done;
    logic [1:0] state;

    microwave_sequencer #(.CLK_PER_SEC(CPS), .TICK_W(4)) dut (
        .clock(clock), .clear(clear), .keypad(keypad), .startn(startn),
        .stopn(stopn), .door_closed(door_closed), .min_bcd(min_bcd),
        .sec_tens_bcd(sec_tens_bcd), .sec_ones_bcd(sec_ones_bcd),
        .mag_on(mag_on), .state(state), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] mn, tn, on;
        logic       mag, dn;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    // Reference model: time held as total seconds, events delayed one cycle.
    int m_st, m_min, m_tens, m_ones, m_cnt, m_digit;
    bit m_mag, m_done, m_key_ev, m_start_ev, m_stop_ev;
    bit m_any_d, m_startn_d, m_stopn_d;

    task automatic set_secs(input int s);
        m_min  = s / 60;
        m_tens = (s % 60) / 10;
        m_ones = s % 10;
    endtask

    task automatic model_edge();
        int secs, nxt;
        bit tick;
        if (clear) begin
            m_st = S_IDLE; set_secs(0); m_cnt = 0; m_mag = 0; m_done = 0;
            m_key_ev = 0; m_start_ev = 0; m_stop_ev = 0;
        end else begin
            nxt   = m_st;
            secs  = m_min * 60 + m_tens * 10 + m_ones;
            m_mag = (m_st == S_COOK);
            case (m_st)
                S_IDLE: begin
                    if (m_stop_ev) set_secs(0);
                    else if (m_start_ev && door_closed && secs != 0) begin nxt = S_COOK; m_cnt = 0; end
`ifdef QUICK_START_EN
                    else if (m_start_ev && door_closed) begin nxt = S_COOK; m_cnt = 0; set_secs(30); end
`endif
                    else if (m_key_ev) begin
                        m_min  = m_tens;
                        m_tens = (m_ones > 5) ? 5 : m_ones;
                        m_ones = m_digit;
                    end
                end
                S_COOK: begin
                    if (!door_closed || m_stop_ev) nxt = S_PAUSE;
                    else begin
                        tick  = (m_cnt == CPS - 1);
                        m_cnt = (m_cnt + 1) % CPS;
                        if (tick) secs = secs - 1;
`ifdef QUICK_START_EN
                        if (m_start_ev) secs = (secs + 30 > 599) ? 599 : secs + 30;
`endif
                        set_secs(secs);
                        if (secs == 0) nxt = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (m_stop_ev) begin nxt = S_IDLE; set_secs(0); end
                    else if (m_start_ev && door_closed) nxt = S_COOK;
                end
                default: if (m_key_ev || m_start_ev || m_stop_ev) nxt = S_IDLE;
            endcase
            m_done = (nxt == S_DONE) && (m_st != S_DONE);
            m_st   = nxt;
            m_key_ev   = (keypad != 10'd0) && !m_any_d;
            m_start_ev = m_startn_d && !startn;
            m_stop_ev  = m_stopn_d && !stopn;
            m_digit = 0;
            for (int i = 9; i >= 0; i--) if (keypad[i]) begin m_digit = i; break; end
        end
        m_any_d    = (keypad != 10'd0);
        m_startn_d = startn;
        m_stopn_d  = stopn;
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        e.st = 2'(m_st); e.mn = 4'(m_min); e.tn = 4'(m_tens); e.on = 4'(m_ones);
        e.mag = m_mag; e.dn = m_done;
        return e;
    endfunction

    function automatic obs_t dut_obs();
        return {state, min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, done};
    endfunction

    always @(negedge clock) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            n_cycle++;
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_%0d: got st=%b %h:%h%h mag=%b done=%b, expected st=%b %h:%h%h mag=%b done=%b",
                          n_cycle, a.st, a.mn, a.tn, a.on, a.mag, a.dn, e.st, e.mn, e.tn, e.on, e.mag, e.dn);
        end
    end

    // Inputs change just after the falling edge; the model predicts the next rising edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_edge();
            exp_q.push_back(model_obs());
            @(negedge clock);
            #1;
        end
    endtask

    task automatic press_key(input int d);
        keypad = 10'b1 << d; step(1);
        keypad = 10'd0;      step(1);
    endtask

    task automatic press_start();
        startn = 1'b0; step(1);
        startn = 1'b1; step(1);
    endtask

    task automatic press_stop();
        stopn = 1'b0; step(1);
        stopn = 1'b1; step(1);
    endtask

    task automatic check_now(input string name, input obs_t exp);
        obs_t a;
        a = dut_obs();
        n_checks++;
        if (a === exp) n_pass++;
        else $display("FAIL %s: got st=%b %h:%h%h mag=%b done=%b, expected st=%b %h:%h%h mag=%b done=%b",
                      name, a.st, a.mn, a.tn, a.on, a.mag, a.dn, exp.st, exp.mn, exp.tn, exp.on, exp.mag, exp.dn);
    endtask

    initial begin
        int r;
        clear = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        step(3);
        clear = 1'b0;
        step(2);
        check_now("reset", {2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});

        press_key(2); press_key(5); press_key(9); press_key(0); press_key(0);
        step(2);
        check_now("entry_5_00", {2'b00, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0});

        press_stop(); press_key(1); press_key(2); press_start();
        step(35);
        press_stop(); press_stop(); step(2);

        press_key(1); press_key(0); press_key(0); press_start();
        step(14);
        press_stop(); press_stop();
        press_key(1); press_start();
        step(15);
        press_key(3); step(3);
        check_now("done_exit_no_entry", {2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});

        press_key(5); press_start();
        step(14);
        door_closed = 1'b0; step(4);
        door_closed = 1'b1; step(2);
        press_start(); step(20);
        press_stop(); press_stop();

        press_key(7); door_closed = 1'b0; press_start(); step(3);
        check_now("start_door_open", {2'b00, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0});
        door_closed = 1'b1; press_stop(); press_start(); step(3);

        press_stop(); press_stop();
        press_key(4); press_key(5); press_start(); step(12);
        startn = 1'b0; stopn = 1'b0; step(1);
        startn = 1'b1; stopn = 1'b1; step(4);
        press_stop(); step(2);

        press_key(3); press_key(1); press_key(7); press_start(); step(25);
        clear = 1'b1; step(1);
        check_now("clear_mid_cook", {2'b00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});
        clear = 1'b0; step(2);

`ifdef QUICK_START_EN
        press_key(9); press_key(4); press_key(5); press_start(); step(3);
        press_start(); step(3);
        press_stop(); press_stop();
`endif

        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            clear = ($urandom_range(0, 499) == 0);
            if (r < 8)       keypad = 10'b1 << $urandom_range(0, 9);
            else if (r < 10) keypad = 10'($urandom);
            else if (r >= 60) keypad = 10'd0;
            startn = ($urandom_range(0, 24) != 0);
            stopn  = ($urandom_range(0, 89) != 0);
            if ($urandom_range(0, 119) == 0) door_closed = ~door_closed;
            step(1);
        end
        clear = 1'b0; keypad = 10'd0; startn = 1'b1; stopn = 1'b1;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
